// File: rtl/qspi_ram_pkg.sv
// Shared types and constants for the QSPI PSRAM arbiter and its nibble PHY.
package qspi_ram_pkg;

    typedef enum logic [3:0] {
        StInitWait,
        StInitCmd,
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StDataRd,
        StDataWr,
        StGap
    } state_e;

    localparam logic [7:0] CMD_QPI_ENTER = 8'h35;
    localparam logic [7:0] CMD_QREAD     = 8'hEB;
    localparam logic [7:0] CMD_QWRITE    = 8'h38;

    localparam int unsigned CMD_NIBBLES  = 2;
    localparam int unsigned ADDR_NIBBLES = 6;
    localparam int unsigned DATA_NIBBLES = 2;

endpackage

// File: rtl/qspi_ram_phy.sv
// Slot sequencer: each slot is two clk cycles (ram_clk low, then high); shifts a
// 32-bit word out MSB first, one nibble or one bit per slot, and shifts nibbles in.
module qspi_ram_phy (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        quad_i,
    input  logic [3:0]  count_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  io_i,
    output logic [3:0]  io_o,
    output logic        sclk_o,
    output logic        done_o,
    output logic [7:0]  rx_o
);

    logic        active_q;
    logic        phase_q;
    logic        quad_q;
    logic [3:0]  cnt_q;
    logic [31:0] shift_q;
    logic [3:0]  rx_q;
    logic        slot_end;

    assign slot_end = active_q & phase_q;
    assign done_o   = slot_end & (cnt_q == 4'd0);
    assign sclk_o   = slot_end;
    assign io_o     = quad_q ? shift_q[31:28] : {3'b000, shift_q[31]};
    // Combine with the live input so the caller can capture the byte on the last edge.
    assign rx_o     = {rx_q, io_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            quad_q   <= 1'b0;
            cnt_q    <= 4'd0;
            shift_q  <= 32'h0;
            rx_q     <= 4'h0;
        end else begin
            if (slot_end) begin
                rx_q <= io_i;
            end
            if (load_i) begin
                active_q <= 1'b1;
                phase_q  <= 1'b0;
                quad_q   <= quad_i;
                cnt_q    <= count_i - 4'd1;
                shift_q  <= data_i;
            end else if (active_q) begin
                phase_q <= ~phase_q;
                if (slot_end) begin
                    if (cnt_q == 4'd0) begin
                        active_q <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                        shift_q <= quad_q ? {shift_q[27:0], 4'h0} : {shift_q[30:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/qspi_ram_arbiter.sv
// Two-port round-robin arbiter and QPI sequencer for an external PSRAM; puts the
// RAM into QPI mode after reset, then runs single-byte reads and writes.
module qspi_ram_arbiter
    import qspi_ram_pkg::*;
#(
    parameter int unsigned DUMMY_NIBBLES = 6,
    parameter int unsigned INIT_CYCLES   = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [25:0] req0_addr,
    input  logic [7:0]  req0_wdata,
    output logic        rsp0_valid,
    output logic [7:0]  rsp0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [25:0] req1_addr,
    input  logic [7:0]  req1_wdata,
    output logic        rsp1_valid,
    output logic [7:0]  rsp1_data,
    output logic        busy,
    output logic        ram_csn,
    output logic        ram_clk,
    output logic [1:0]  ram_bank,
    output logic [3:0]  ram_io_o,
    output logic [3:0]  ram_io_oe,
    input  logic [3:0]  ram_io_i
);

    localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [InitW-1:0]   init_cnt_q, init_cnt_d;
    logic               prio_q, prio_d;
    logic               port_q, port_d;
    logic               we_q, we_d;
    logic [25:0]        addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [7:0]         rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
    logic               gnt_port;

    logic               phy_load, phy_quad, phy_done, phy_sclk;
    logic [3:0]         phy_count, phy_io;
    logic [31:0]        phy_data;
    logic [7:0]         phy_rx;

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        prio_d       = prio_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        gnt_port     = 1'b0;
        phy_load     = 1'b0;
        phy_quad     = 1'b1;
        phy_count    = 4'(DATA_NIBBLES);
        phy_data     = 32'h0;
        case (state_q)
            StInitWait: begin
                if (init_cnt_q == InitW'(INIT_CYCLES - 1)) begin
                    state_d   = StInitCmd;
                    phy_load  = 1'b1;
                    phy_quad  = 1'b0;
                    phy_count = 4'd8;
                    phy_data  = {CMD_QPI_ENTER, 24'h0};
                end else begin
                    init_cnt_d = init_cnt_q + InitW'(1);
                end
            end
            StInitCmd: if (phy_done) state_d = StGap;
            StIdle: begin
                if (req0_valid || req1_valid) begin
                    // Contention goes to the port that was not served last.
                    gnt_port   = (req0_valid && req1_valid) ? prio_q : req1_valid;
                    req0_ready = ~gnt_port;
                    req1_ready = gnt_port;
                    prio_d     = ~gnt_port;
                    port_d     = gnt_port;
                    we_d       = gnt_port ? req1_we : req0_we;
                    addr_d     = gnt_port ? req1_addr : req0_addr;
                    wdata_d    = gnt_port ? req1_wdata : req0_wdata;
                    state_d    = StCmd;
                    phy_load   = 1'b1;
                    phy_count  = 4'(CMD_NIBBLES);
                    phy_data   = {(we_d ? CMD_QWRITE : CMD_QREAD), 24'h0};
                end
            end
            StCmd: begin
                if (phy_done) begin
                    state_d   = StAddr;
                    phy_load  = 1'b1;
                    phy_count = 4'(ADDR_NIBBLES);
                    phy_data  = {addr_q[23:0], 8'h0};
                end
            end
            StAddr: begin
                if (phy_done) begin
                    phy_load = 1'b1;
                    if (we_q) begin
                        state_d  = StDataWr;
                        phy_data = {wdata_q, 24'h0};
                    end else if (DUMMY_NIBBLES == 0) begin
                        state_d = StDataRd;
                    end else begin
                        state_d   = StDummy;
                        phy_count = 4'(DUMMY_NIBBLES);
                    end
                end
            end
            StDummy: begin
                if (phy_done) begin
                    state_d  = StDataRd;
                    phy_load = 1'b1;
                end
            end
            StDataRd: begin
                if (phy_done) begin
                    state_d = StGap;
                    if (port_q) begin
                        rsp1_valid_d = 1'b1;
                        rsp1_data_d  = phy_rx;
                    end else begin
                        rsp0_valid_d = 1'b1;
                        rsp0_data_d  = phy_rx;
                    end
                end
            end
            StDataWr: if (phy_done) state_d = StGap;
            StGap:    state_d = StIdle;
            default:  state_d = StInitWait;
        endcase
    end

    // Pin levels decode straight from the state so an async reset clears them at once.
    always_comb begin
        ram_csn   = 1'b0;
        ram_io_oe = 4'b0000;
        case (state_q)
            StInitWait, StIdle, StGap: ram_csn = 1'b1;
            StInitCmd:                 ram_io_oe = 4'b0001;
            StCmd, StAddr, StDataWr:   ram_io_oe = 4'b1111;
            default:                   ram_io_oe = 4'b0000;
        endcase
    end

    assign ram_io_o   = phy_io & ram_io_oe;
    assign ram_clk    = phy_sclk;
    assign ram_bank   = addr_q[25:24];
    assign busy       = (state_q != StIdle);
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInitWait;
            init_cnt_q   <= '0;
            prio_q       <= 1'b0;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 26'h0;
            wdata_q      <= 8'h0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= 8'h0;
            rsp1_data_q  <= 8'h0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            prio_q       <= prio_d;
            port_q       <= port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    qspi_ram_phy u_phy (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (phy_load),
        .quad_i  (phy_quad),
        .count_i (phy_count),
        .data_i  (phy_data),
        .io_i    (ram_io_i),
        .io_o    (phy_io),
        .sclk_o  (phy_sclk),
        .done_o  (phy_done),
        .rx_o    (phy_rx)
    );

endmodule

// File: tb/tb_qspi_ram_arbiter.sv
// Directed + randomized bench for qspi_ram_arbiter with a pin-level PSRAM stand-in.
module tb_qspi_ram_arbiter;

    localparam int unsigned INIT  = 200;
    localparam int unsigned DUMMY = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
    logic [25:0] req0_addr = '0, req1_addr = '0;
    logic [7:0]  req0_wdata = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [7:0]  rsp0_data, rsp1_data;
    logic        ram_csn, ram_clk;
    logic [1:0]  ram_bank;
    logic [3:0]  ram_io_o, ram_io_oe;
    logic [3:0]  ram_io_i = 4'h0;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          slot = 0;
    int          pref = 0;
    logic [7:0]  rd_byte = 8'h00;
    logic [7:0]  nibs[$];
    logic [8:0]  rsp_q[$];

    logic        we_t[2];
    logic [25:0] ad_t[2];
    logic [7:0]  wd_t[2];
    logic [7:0]  rd_t[2];

    qspi_ram_arbiter #(
        .DUMMY_NIBBLES (DUMMY),
        .INIT_CYCLES   (INIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .busy       (busy),
        .ram_csn    (ram_csn),
        .ram_clk    (ram_clk),
        .ram_bank   (ram_bank),
        .ram_io_o   (ram_io_o),
        .ram_io_oe  (ram_io_oe),
        .ram_io_i   (ram_io_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // PSRAM stand-in: records every slot seen while selected and, during a read,
    // presents the two data nibbles in slots 8+DUMMY and 9+DUMMY.
    always @(negedge clk) begin
        if (ram_csn) begin
            slot <= 0;
        end else if (ram_clk) begin
            nibs.push_back({ram_io_oe, ram_io_o});
            slot <= slot + 1;
        end else begin
            if (slot == 8 + DUMMY)      ram_io_i <= rd_byte[7:4];
            else if (slot == 9 + DUMMY) ram_io_i <= rd_byte[3:0];
            else                        ram_io_i <= 4'($urandom);
        end
        if (rsp0_valid) rsp_q.push_back({1'b0, rsp0_data});
        if (rsp1_valid) rsp_q.push_back({1'b1, rsp1_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int p, input logic we, input logic [25:0] a, input logic [7:0] wd);
        if (p == 1) begin
            req1_we = we; req1_addr = a; req1_wdata = wd; req1_valid = 1'b1;
        end else begin
            req0_we = we; req0_addr = a; req0_wdata = wd; req0_valid = 1'b1;
        end
    endtask

    task automatic drop(input int p);
        if (p == 1) req1_valid = 1'b0;
        else        req0_valid = 1'b0;
    endtask

    task automatic wait_grant(input int p, output int t);
        bit found = 1'b0;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if ((p == 1) ? req1_ready : req0_ready) begin
                found = 1'b1;
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        check("grant_seen", 32'(found), 1);
        check("other_ready", 32'((p == 1) ? req0_ready : req1_ready), 0);
        pref = 1 - p;
        nibs.delete();
        rsp_q.delete();
        @(posedge clk);
        #1;
        drop(p);
    endtask

    task automatic check_init(input int p, output int t);
        int rel = cyc;
        int first_low = -1;
        int gp = -1;
        t = -1;
        for (int i = 0; i < int'(INIT) + 100; i++) begin
            @(negedge clk);
            if (!ram_csn && first_low < 0) first_low = cyc;
            if (req0_ready || req1_ready) begin
                t = cyc;
                gp = req1_ready ? 1 : 0;
                break;
            end
        end
        check("init_csn_low", 32'(first_low - rel), INIT);
        check("init_grant_cycle", 32'(t - rel), INIT + 17);
        check("init_grant_port", 32'(gp), 32'(p));
        check("init_bits", 32'(nibs.size()), 8);
        for (int i = 0; i < 8 && i < nibs.size(); i++) begin
            logic [7:0] cmd = 8'h35;
            check("init_bit", 32'(nibs[i]), {24'h0, 4'b0001, 3'b000, cmd[7-i]});
        end
        pref = 1 - p;
        nibs.delete();
        rsp_q.delete();
        @(posedge clk);
        #1;
        drop(p);
    endtask

    task automatic finish_txn(input int p, input logic we, input logic [25:0] a,
                              input logic [7:0] wd, input logic [7:0] rd, input int t);
        logic [7:0] exp_n[$];
        logic [7:0] cmd = we ? 8'h38 : 8'hEB;
        int g = -1;
        @(negedge clk);
        check("csn_fall", 32'(ram_csn), 0);
        check("bank", 32'(ram_bank), 32'(a[25:24]));
        check("busy_xfer", 32'(busy), 1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ram_csn) begin
                g = cyc;
                break;
            end
        end
        check("gap_cycle", 32'(g - t), we ? 21 : 33);
        check("rsp0_valid_gap", 32'(rsp0_valid), 32'(!we && p == 0));
        check("rsp1_valid_gap", 32'(rsp1_valid), 32'(!we && p == 1));
        if (!we) check("rsp_data_gap", 32'((p == 1) ? rsp1_data : rsp0_data), 32'(rd));
        exp_n.push_back({4'hF, cmd[7:4]});
        exp_n.push_back({4'hF, cmd[3:0]});
        for (int i = 5; i >= 0; i--) exp_n.push_back({4'hF, 4'(a >> (4 * i))});
        if (we) begin
            exp_n.push_back({4'hF, wd[7:4]});
            exp_n.push_back({4'hF, wd[3:0]});
        end else begin
            for (int i = 0; i < int'(DUMMY) + 2; i++) exp_n.push_back(8'h00);
        end
        check("nib_count", 32'(nibs.size()), 32'(exp_n.size()));
        for (int i = 0; i < exp_n.size() && i < nibs.size(); i++)
            check("nibble", 32'(nibs[i]), 32'(exp_n[i]));
        @(negedge clk);
        check("rsp_pulses", 32'(rsp_q.size()), we ? 0 : 1);
        if (!we && rsp_q.size() > 0) check("rsp_entry", 32'(rsp_q[0]), 32'({p[0], rd}));
        check("idle_after_gap", 32'(busy), 0);
        rsp_q.delete();
    endtask

    task automatic rand_port(input int p);
        we_t[p] = 1'($urandom);
        ad_t[p] = 26'($urandom);
        wd_t[p] = 8'($urandom);
        rd_t[p] = 8'($urandom);
        issue(p, we_t[p], ad_t[p], wd_t[p]);
    endtask

    initial begin
        int t, p, prev_t, prev_p;
        logic prev_we;
        logic [7:0] prev_rd;
        logic [25:0] a;
        logic [7:0] d;

        // Reset values, with a request present so ready is meaningful.
        req0_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_csn", 32'(ram_csn), 1);
        check("rst_clk", 32'(ram_clk), 0);
        check("rst_oe", 32'(ram_io_oe), 0);
        check("rst_io", 32'(ram_io_o), 0);
        check("rst_bank", 32'(ram_bank), 0);
        check("rst_ready0", 32'(req0_ready), 0);
        check("rst_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
        check("rst_data", 32'({rsp0_data, rsp1_data}), 0);
        check("rst_busy", 32'(busy), 1);
        req0_valid = 1'b0;

        // Port 1 write waits through the whole init sequence, then is served first.
        a = 26'($urandom);
        d = 8'($urandom);
        issue(1, 1'b1, a, d);
        rst_n = 1'b1;
        check_init(1, t);
        finish_txn(1, 1'b1, a, d, 8'h00, t);

        // Directed read and write.
        rd_byte = 8'hA5;
        issue(0, 1'b0, 26'h2123456, 8'h00);
        wait_grant(0, t);
        finish_txn(0, 1'b0, 26'h2123456, 8'h00, 8'hA5, t);

        issue(1, 1'b1, 26'h0000010, 8'h3C);
        wait_grant(1, t);
        finish_txn(1, 1'b1, 26'h0000010, 8'h3C, 8'h00, t);

        // Randomized single-port traffic.
        for (int k = 0; k < 6; k++) begin
            p = int'($urandom_range(0, 1));
            rand_port(p);
            rd_byte = rd_t[p];
            wait_grant(p, t);
            finish_txn(p, we_t[p], ad_t[p], wd_t[p], rd_t[p], t);
        end

        // Both ports valid continuously: grants must alternate, back to back.
        rand_port(0);
        rand_port(1);
        prev_t = 0; prev_p = 0; prev_we = 1'b0; prev_rd = 8'h00;
        for (int k = 0; k < 8; k++) begin
            bit found = 1'b0;
            for (int i = 0; i < 80; i++) begin
                #1;
                if (req0_ready || req1_ready) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            t = cyc;
            p = req1_ready ? 1 : 0;
            check("rr_grant_seen", 32'(found), 1);
            check("rr_single_ready", 32'(req0_ready & req1_ready), 0);
            check("rr_port", 32'(p), 32'(pref));
            if (k > 0) begin
                check("rr_spacing", 32'(t - prev_t), prev_we ? 22 : 34);
                check("rr_nibs", 32'(nibs.size()), prev_we ? 10 : 16);
                check("rr_rsp_pulses", 32'(rsp_q.size()), prev_we ? 0 : 1);
                if (!prev_we && rsp_q.size() > 0)
                    check("rr_rsp_entry", 32'(rsp_q[0]), 32'({prev_p[0], prev_rd}));
            end
            nibs.delete();
            rsp_q.delete();
            rd_byte = rd_t[p];
            prev_t = t; prev_p = p; prev_we = we_t[p]; prev_rd = rd_t[p];
            pref = 1 - p;
            @(posedge clk);
            #1;
            if (k == 7) begin
                drop(0);
                drop(1);
            end else begin
                rand_port(p);
            end
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("rr_last_nibs", 32'(nibs.size()), prev_we ? 10 : 16);
        check("rr_last_rsp", 32'(rsp_q.size()), prev_we ? 0 : 1);
        rsp_q.delete();

        // Reset during ADDR: pins drop at once, no response, full init reruns.
        rd_byte = 8'h5A;
        issue(0, 1'b0, 26'($urandom), 8'h00);
        wait_grant(0, t);
        while (cyc < t + 8) @(negedge clk);
        check("addr_csn", 32'(ram_csn), 0);
        check("addr_clk_high", 32'(ram_clk), 1);
        check("addr_oe", 32'(ram_io_oe), 4'hF);
        rst_n = 1'b0;
        #1;
        check("abort_csn", 32'(ram_csn), 1);
        check("abort_clk", 32'(ram_clk), 0);
        check("abort_oe", 32'(ram_io_oe), 0);
        check("abort_io", 32'(ram_io_o), 0);
        check("abort_busy", 32'(busy), 1);
        check("abort_rsp0_data", 32'(rsp0_data), 0);
        a = 26'($urandom);
        rd_byte = 8'hC3;
        issue(0, 1'b0, a, 8'h00);
        repeat (3) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_q.size()), 0);
        check("abort_no_ready", 32'(req0_ready), 0);
        nibs.delete();
        pref = 0;
        rst_n = 1'b1;
        check_init(0, t);
        finish_txn(0, 1'b0, a, 8'h00, 8'hC3, t);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
